// File: rtl/sm83_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm83_bus_pkg
// Brief    : Shared types, illegal-opcode table and RST vector helper for the
//            SM83 memory-bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sm83_bus_pkg;

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        WAIT = 3'd4
    } phase_t;

    typedef logic [7:0] word_t;

    localparam int N_ILLEGAL = 11;

    // Unassigned SM83 opcodes in the unprefixed bank
    localparam word_t ILLEGAL_OPS [N_ILLEGAL] = '{
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
        8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

    // RST opcode for a given interrupt number: 11 nnn 111
    function automatic word_t rst_vec(input logic [2:0] int_num);
        return {2'b11, int_num, 3'b111};
    endfunction

    function automatic logic is_illegal_op(input word_t op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_ILLEGAL; i++) begin
            if (op == ILLEGAL_OPS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm83_bus_phase.sv
`default_nettype none
// ============================================================================
// Module   : sm83_bus_phase
// Brief    : T1..T4 sequencer with ready-driven wait states, wait timeout and
//            sticky bus-error flag. Strobes are registered.
// Revision : 1.0 - initial release
// ============================================================================
module sm83_bus_phase
    import sm83_bus_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic ext_ready_i,
    output logic t1_o,
    output logic t2_o,
    output logic t3_o,
    output logic t4_o,
    output logic stall_o,
    output logic bus_err_o
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    phase_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q, bus_err_d;
    logic       t1_q, t2_q, t3_q, t4_q, stall_q;

    // Next phase, wait count and error flag
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            T1: state_d = T2;
            T2: state_d = T3;
            T3: begin
                if (active_i && !ext_ready_i) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = T4;
                end
            end
            T4: state_d = T1;
            WAIT: begin
                if (ext_ready_i) begin
                    state_d = T4;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d   = T4;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = T4;
        endcase
    end

    // State register with strobes registered from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= T4;
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
            t1_q       <= 1'b0;
            t2_q       <= 1'b0;
            t3_q       <= 1'b0;
            t4_q       <= 1'b1;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
            t1_q       <= (state_d == T1);
            t2_q       <= (state_d == T2);
            t3_q       <= (state_d == T3);
            t4_q       <= (state_d == T4);
            stall_q    <= (state_d == WAIT);
        end
    end

    assign t1_o      = t1_q;
    assign t2_o      = t2_q;
    assign t3_o      = t3_q;
    assign t4_o      = t4_q;
    assign stall_o   = stall_q;
    assign bus_err_o = bus_err_q;

endmodule
`default_nettype wire

// File: rtl/sm83_bus_seq.sv
`default_nettype none
// ============================================================================
// Module   : sm83_bus_seq
// Brief    : SM83 memory-bus interface: owns the T-state sequencer, request
//            latching, address/data latches, instruction register with CB
//            bank and illegal-opcode detection.
// Revision : 1.0 - initial release
// ============================================================================
module sm83_bus_seq
    import sm83_bus_pkg::*;
#(
    parameter int AW       = 16,
    parameter int CLR_LSB  = 8,
    parameter int INT_W    = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mread_i,
    input  logic             mwrite_i,
    input  logic             ext_ready_i,
    output logic             t1_o,
    output logic             t2_o,
    output logic             t3_o,
    output logic             t4_o,
    output logic             stall_o,
    output logic             rd_o,
    output logic             wr_o,
    output logic             bus_err_o,
    input  logic             apin_we_i,
    input  logic [AW-1:0]    ain_i,
    output logic [AW-1:0]    aout_o,
    input  logic             dl_we_i,
    input  logic [7:0]       din_i,
    output logic [7:0]       dout_o,
    input  logic [7:0]       ext_din_i,
    output logic [7:0]       ext_dout_o,
    input  logic [7:0]       iena_i,
    input  logic             iena_sel_i,
    input  logic [INT_W-1:0] int_num_i,
    input  logic             ctl_ir_we_i,
    input  logic             ctl_ir_bank_we_i,
    input  logic             ctl_ir_bank_cb_set_i,
    input  logic             ctl_zero_data_oe_i,
    input  logic             ctl_rst_data_oe_i,
    output logic [7:0]       opcode_o,
    output logic             bank_cb_o,
    output logic             illegal_o
);

    // Low address bits that survive the end-of-cycle clear
    localparam logic [AW-1:0] KEEP_MASK = {{(AW-CLR_LSB){1'b0}}, {CLR_LSB{1'b1}}};

    logic          t4;
    logic          rd_q, wr_q;
    logic [AW-1:0] aout_q;
    word_t         data_q;
    word_t         opcode_q;
    logic          bank_cb_q;
    word_t         data_t4;
    word_t         rst_opcode;

    sm83_bus_phase #(
        .MAX_WAIT (MAX_WAIT)
    ) u_phase (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .active_i    (rd_q | wr_q),
        .ext_ready_i (ext_ready_i),
        .t1_o        (t1_o),
        .t2_o        (t2_o),
        .t3_o        (t3_o),
        .t4_o        (t4),
        .stall_o     (stall_o),
        .bus_err_o   (bus_err_o)
    );

    assign rst_opcode = rst_vec(int_num_i[2:0]);

    // Value presented on the internal data path during T4
    always_comb begin
        data_t4 = ext_din_i;
        if (ctl_zero_data_oe_i) begin
            data_t4 = 8'h00;
        end else if (ctl_rst_data_oe_i) begin
            data_t4 = rst_opcode;
        end else if (iena_sel_i) begin
            data_t4 = iena_i;
        end
    end

    // Bus requests are only accepted in T4 and hold for the whole next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else if (t4) begin
            rd_q <= mread_i;
            wr_q <= mwrite_i & ~mread_i;
        end
    end

    // Address latch: explicit load beats the end-of-cycle high-bit clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aout_q <= '0;
        end else if (apin_we_i) begin
            aout_q <= ain_i;
        end else if (t4) begin
            aout_q <= aout_q & KEEP_MASK;
        end
    end

    // Data latch; read data is captured only in T4 of a read cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= 8'h00;
        end else if (ctl_zero_data_oe_i) begin
            data_q <= 8'h00;
        end else if (ctl_rst_data_oe_i) begin
            data_q <= rst_opcode;
        end else if (dl_we_i) begin
            data_q <= din_i;
        end else if (rd_q && t4) begin
            data_q <= data_t4;
        end
    end

    // Instruction register and CB-prefix bank
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q  <= 8'h00;
            bank_cb_q <= 1'b0;
        end else begin
            if (ctl_ir_we_i) begin
                opcode_q <= data_t4;
            end
            if (ctl_ir_bank_we_i) begin
                bank_cb_q <= ctl_ir_bank_cb_set_i;
            end
        end
    end

    assign t4_o       = t4;
    assign rd_o       = rd_q;
    assign wr_o       = wr_q;
    assign aout_o     = aout_q;
    assign dout_o     = (rd_q && t4) ? data_t4 : data_q;
    assign ext_dout_o = data_q;
    assign opcode_o   = ctl_ir_we_i ? data_t4 : opcode_q;
    assign bank_cb_o  = bank_cb_q;
    assign illegal_o  = ~bank_cb_q & is_illegal_op(opcode_o);

endmodule
`default_nettype wire

// File: tb/tb_sm83_bus_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm83_bus_seq
// Brief    : Self-checking bench for sm83_bus_seq: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural bus-cycle model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm83_bus_seq;

    localparam int AW = 16;
    localparam int MW = 4;

    logic clk, rst_n;
    logic mread, mwrite, ext_ready, apin_we, dl_we, iena_sel;
    logic ir_we, bank_we, bank_set, zero_oe, rst_oe;
    logic [AW-1:0] ain;
    logic [7:0] din, ext_din, iena;
    logic [2:0] int_num;
    logic t1, t2, t3, t4, stall, rd, wr, bus_err, bank_cb, illegal;
    logic [AW-1:0] aout;
    logic [7:0] dout, ext_dout, opcode;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    sm83_bus_seq #(.AW(AW), .CLR_LSB(8), .INT_W(3), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mread_i(mread), .mwrite_i(mwrite),
        .ext_ready_i(ext_ready), .t1_o(t1), .t2_o(t2), .t3_o(t3), .t4_o(t4),
        .stall_o(stall), .rd_o(rd), .wr_o(wr), .bus_err_o(bus_err),
        .apin_we_i(apin_we), .ain_i(ain), .aout_o(aout), .dl_we_i(dl_we),
        .din_i(din), .dout_o(dout), .ext_din_i(ext_din), .ext_dout_o(ext_dout),
        .iena_i(iena), .iena_sel_i(iena_sel), .int_num_i(int_num),
        .ctl_ir_we_i(ir_we), .ctl_ir_bank_we_i(bank_we),
        .ctl_ir_bank_cb_set_i(bank_set), .ctl_zero_data_oe_i(zero_oe),
        .ctl_rst_data_oe_i(rst_oe), .opcode_o(opcode), .bank_cb_o(bank_cb),
        .illegal_o(illegal)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_ph: 0..3 = T1..T4, 4 = stalled waiting for the device
    int          m_ph, m_waits;
    bit          m_rd, m_wr, m_err, m_bank;
    logic [15:0] m_aout;
    logic [7:0]  m_data, m_op;

    function automatic logic [7:0] m_bus_val();
        if (zero_oe) return 8'h00;
        if (rst_oe)  return 8'hC7 + 8'(int_num) * 8'd8;
        if (iena_sel) return iena;
        return ext_din;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 3; m_waits = 0; m_rd = 0; m_wr = 0; m_err = 0;
            m_bank = 0; m_aout = 0; m_data = 0; m_op = 0;
        end else begin
            automatic logic [7:0] bv = m_bus_val();
            automatic bit in_t4 = (m_ph == 3);
            automatic bit busy = m_rd || m_wr;
            if (zero_oe)                m_data = 8'h00;
            else if (rst_oe)            m_data = bv;
            else if (dl_we)             m_data = din;
            else if (m_rd && in_t4)     m_data = bv;
            if (apin_we)                m_aout = ain;
            else if (in_t4)             m_aout = m_aout % 256;
            if (ir_we)   m_op = bv;
            if (bank_we) m_bank = bank_set;
            if (in_t4) begin
                m_rd = mread;
                m_wr = mwrite && !mread;
            end
            if (m_ph == 4) begin
                m_waits++;
                if (ext_ready) m_ph = 3;
                else if (m_waits >= MW) begin m_ph = 3; m_err = 1; end
            end else if (m_ph == 2 && busy && !ext_ready) begin
                m_ph = 4; m_waits = 0;
            end else begin
                m_ph = (m_ph + 1) % 4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            automatic logic [7:0] bv = m_bus_val();
            automatic logic [7:0] eop = ir_we ? bv : m_op;
            automatic bit ill = !m_bank && (eop inside {8'hD3, 8'hDB, 8'hDD, 8'hE3,
                8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD});
            chk("m_strobes", {t1, t2, t3, t4, stall},
                {m_ph == 0, m_ph == 1, m_ph == 2, m_ph == 3, m_ph == 4});
            chk("m_rdwr", {rd, wr}, {m_rd, m_wr});
            chk("m_bus_err", bus_err, m_err);
            chk("m_aout", aout, m_aout);
            chk("m_dout", dout, (m_rd && m_ph == 3) ? bv : m_data);
            chk("m_ext_dout", ext_dout, m_data);
            chk("m_opcode", opcode, eop);
            chk("m_bank_cb", bank_cb, m_bank);
            chk("m_illegal", illegal, ill);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        mread = 0; mwrite = 0; ext_ready = 1; apin_we = 0; dl_we = 0;
        iena_sel = 0; ir_we = 0; bank_we = 0; bank_set = 0; zero_oe = 0;
        rst_oe = 0; ain = 0; din = 0; ext_din = 0; iena = 0; int_num = 0;
    endtask

    task automatic go_t4();
        for (int i = 0; i < 20; i++) begin
            if (m_ph == 3) return;
            tick();
        end
        chk("go_t4_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 0; tick(); tick(); rst_n = 1;
    endtask

    initial begin
        int n;
        clear_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        chk_en = 1;

        // 1: read right after reset release
        mread = 1; ext_din = 8'h3C;
        tick(); rst_n = 1;
        chk("rst_t4", {t1, t2, t3, t4}, 4'b0001);
        chk("rst_rdwr_err", {rd, wr, stall, bus_err}, 4'b0000);
        chk("rst_aout", aout, 0);
        tick(); mread = 0;
        chk("rd_t1", {t1, rd}, 2'b11);
        tick(); tick(); tick();
        chk("rd_t4_dout", {t4, rd, dout}, {2'b11, 8'h3C});
        tick();
        chk("rd_done", {t1, rd, ext_dout}, {2'b10, 8'h3C});

        // 2: three wait states
        go_t4(); mread = 1; tick(); mread = 0;
        tick(); tick(); ext_ready = 0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (stall && !(t1 | t2 | t3 | t4)) n++;
        end
        ext_ready = 1; ext_din = 8'hA5;
        tick();
        chk("wait_stalls", n, 3);
        chk("wait_t4_dout", {t4, stall, bus_err, dout}, {3'b100, 8'hA5});
        tick();
        chk("wait_latched", ext_dout, 8'hA5);

        // 3: timeout
        go_t4(); mread = 1; tick(); mread = 0; ext_ready = 0;
        tick(); tick();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (t4) break;
            n += int'(stall);
        end
        chk("timeout_waits", n, MW);
        chk("timeout_err", {t4, bus_err}, 2'b11);
        ext_ready = 1;
        repeat (6) tick();
        chk("err_sticky", bus_err, 1);
        do_reset();
        chk("err_cleared", bus_err, 0);

        // 4: address latch and high-byte clear
        apin_we = 1; ain = 16'hFF80; tick(); apin_we = 0;
        chk("aout_load", aout, 16'hFF80);
        tick(); tick(); tick();
        chk("aout_held_t4", aout, 16'hFF80);
        tick();
        chk("aout_cleared", aout, 16'h0080);
        go_t4(); apin_we = 1; ain = 16'h1234; tick(); apin_we = 0;
        chk("aout_load_in_t4", aout, 16'h1234);

        // 5: RST vector into IR, zero data
        rst_oe = 1; int_num = 3'd3; ir_we = 1; #1;
        chk("rst_bypass", opcode, 8'hDF);
        tick(); rst_oe = 0; ir_we = 0; #1;
        chk("rst_ir_reg", {opcode, ext_dout}, {8'hDF, 8'hDF});
        zero_oe = 1; tick(); zero_oe = 0; #1;
        chk("zero_dout", dout, 8'h00);

        // 6: illegal detection and request arbitration
        ext_din = 8'hD3; ir_we = 1; bank_we = 1; bank_set = 0;
        tick(); ir_we = 0; bank_we = 0; #1;
        chk("ill_set", {opcode, illegal}, {8'hD3, 1'b1});
        bank_we = 1; bank_set = 1; tick(); bank_we = 0; #1;
        chk("ill_cb", {bank_cb, illegal}, 2'b10);
        go_t4(); mread = 1; mwrite = 1; tick(); mread = 0; mwrite = 0;
        chk("rd_wins", {rd, wr}, 2'b10);
        go_t4(); mwrite = 1; tick(); mwrite = 0;
        chk("wr_only", {rd, wr}, 2'b01);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            mread     = ($urandom_range(0, 9) < 4);
            mwrite    = ($urandom_range(0, 9) < 3);
            ext_ready = ($urandom_range(0, 9) < 6);
            apin_we   = ($urandom_range(0, 9) < 2);
            dl_we     = ($urandom_range(0, 9) < 1);
            zero_oe   = ($urandom_range(0, 19) == 0);
            rst_oe    = ($urandom_range(0, 19) == 0);
            iena_sel  = ($urandom_range(0, 3) == 0);
            ir_we     = ($urandom_range(0, 6) == 0);
            bank_we   = ($urandom_range(0, 9) == 0);
            bank_set  = 1'($urandom);
            ain       = 16'($urandom);
            din       = 8'($urandom);
            ext_din   = ($urandom_range(0, 3) == 0) ? 8'hD3 + 8'($urandom_range(0, 42)) : 8'($urandom);
            iena      = 8'($urandom);
            int_num   = 3'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0; tick(); rst_n = 1;
            end else begin
                tick();
            end
        end

        clear_inputs();
        tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sm83_bus_seq.md
Name: sm83_bus_seq

Overview:
- Parametrised next-generation SM83 memory-bus interface. It owns the T-state sequencer (T1..T4) internally rather than receiving phase strobes.
- Adds wait-state insertion driven by an external ready line, with a timeout and bus-error flag.
- Also carries the address latch, data latch, and instruction register with CB bank.
- Detects illegal opcodes in hardware.
- Sits between the SM83 decoder/control logic and the external bus pins.

Parameters:
- AW, 16: address width.
- CLR_LSB, 8: aout bits [AW-1:CLR_LSB] are zeroed at the end of each M-cycle.
- INT_W, 3: width of int_num. The RST vector is {2'b11, int_num[2:0], 3'b111}; only INT_W=3 is legal.
- MAX_WAIT, 15: maximum consecutive wait states before timeout. Range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mread / mwrite  in  1 / 1  start read / write cycle; sampled only in T4
- ext_ready  in  1  external device ready; sampled in T3 and WAIT
- t1, t2, t3, t4  out  1 each  one-hot phase strobes; all 0 during WAIT
- stall  out  1  high while in WAIT
- rd / wr  out  1 / 1  active bus cycle
- bus_err  out  1  sticky wait-state timeout flag
- apin_we  in  1  load address latch
- ain  in  AW  address from the register file
- aout  out  AW  address pins
- dl_we  in  1  load data latch from din
- din  in  8  internal data bus in
- dout  out  8  internal data bus out
- ext_din  in  8  external data pins in
- ext_dout  out  8  external data pins out
- iena  in  8  interrupt-enable register value
- iena_sel  in  1  read returns iena instead of ext_din
- int_num  in  INT_W  pending interrupt number
- ctl_ir_we, ctl_ir_bank_we, ctl_ir_bank_cb_set  in  1 each  IR write, bank write, CB bank value
- ctl_zero_data_oe, ctl_rst_data_oe  in  1 each  force 0 / RST opcode onto data
- opcode  out  8  current opcode; bypassed when ctl_ir_we
- bank_cb  out  1  CB-prefix bank
- illegal  out  1  current opcode is illegal

Behaviour:
- Reset values (asynchronous, while reset_n low):
  - phase = T4, so t4=1 and t1..t3=0.
  - rd = wr = stall = bus_err = 0.
  - aout = 0, data = 0, opcode_r = 0, bank_cb = 0, wait_cnt = 0.
  - Reset mid-cycle or mid-WAIT aborts the cycle with no error.
- Phase state machine:
  - T1 -> T2 -> T3 -> T4 -> T1, one state per clock.
  - At T3, if (rd || wr) and !ext_ready, go to WAIT and clear wait_cnt.
  - In WAIT: if ext_ready, go to T4. Otherwise, if wait_cnt == MAX_WAIT-1, go to T4 and set bus_err. Otherwise increment wait_cnt.
  - Idle cycles (rd=wr=0) never wait.
- Request handling:
  - In T4: rd <= mread and wr <= mwrite & !mread. If both are requested, the read wins.
  - Outside T4, mread/mwrite are ignored; they are not latched.
  - rd/wr stay constant from T1 through the following T4 inclusive, including any WAIT.
- Address latch:
  - apin_we loads aout <= ain in any state.
  - Otherwise, in T4, aout[AW-1:CLR_LSB] <= 0.
  - apin_we has priority over the clear.
- data_t4 (combinational):
  - If ctl_zero_data_oe: 0.
  - Else if ctl_rst_data_oe: RST vector.
  - Else if iena_sel: iena.
  - Else: ext_din.
- Data latch, priority order:
  1. ctl_zero_data_oe: data <= 0.
  2. ctl_rst_data_oe: data <= RST vector.
  3. dl_we: data <= din.
  4. rd && t4: data <= data_t4.
  5. Otherwise: hold.
  - At most one of ctl_zero_data_oe, ctl_rst_data_oe, dl_we is asserted at once; if more are asserted, the order above applies.
- Data outputs:
  - dout = (rd && t4) ? data_t4 : data.
  - ext_dout = data.
  - WAIT never captures data.
- Instruction register:
  - ctl_ir_we: opcode_r <= data_t4.
  - ctl_ir_bank_we: bank_cb <= ctl_ir_bank_cb_set.
  - opcode = ctl_ir_we ? data_t4 : opcode_r.
- Illegal opcode detection:
  - illegal = !bank_cb && opcode ∈ {D3, DB, DD, E3, E4, EB, EC, ED, F4, FC, FD} (hex).
  - illegal is combinational; the block takes no other action on it.
- Error flag: bus_err clears only on reset.

Decomposition:
- Package sm83_bus_pkg holds:
  - phase_t enum {T1, T2, T3, T4, WAIT};
  - word_t (8-bit);
  - the ILLEGAL_OPS constant array;
  - function rst_vec(int_num).
- One sub-module, sm83_bus_phase: the phase FSM plus wait counter and bus_err.
  - Inputs: active, ext_ready.
  - Outputs: t1..t4, stall, bus_err.
- Address, data, and IR latches stay in the top level.

Test Plan:
1. Reset release with mread=1 held for one T4 -> next clock t1=1 and rd=1; after 4 clocks ext_din=0x3C is latched and dout=0x3C at that T4; rd=0 after the following T4.
2. Read with ext_ready low for 3 clocks from T3 -> stall=1 for exactly 3 clocks with t1..t4=0; then T4 and data captured; bus_err=0.
3. MAX_WAIT=4, ext_ready held low -> 4 WAIT clocks, forced T4, bus_err=1 and still 1 after further cycles until reset_n pulses low.
4. apin_we with ain=0xFF80, then idle T4 -> aout=0x0080; apin_we asserted in the same T4 -> aout=ain, no clear.
5. ctl_rst_data_oe with int_num=3 and ctl_ir_we -> opcode=0xDF on the same clock and opcode_r=0xDF afterwards; ctl_zero_data_oe -> dout=0x00.
6. IR loaded 0xD3 with bank_cb=0 -> illegal=1; set bank_cb=1 -> illegal=0; mread and mwrite together at T4 -> rd=1, wr=0.
